// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame controller: frames destuffed bytes into the Rx buffer.
// Optional FCS check is built when HDLC_RX_FCS_EN is defined.

module hdlc_rx_frame_ctrl #(
  parameter int MAX_BYTES = 128,
  parameter int AW        = 7,
  parameter int MIN_BYTES = 3
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          RxEN,
  input  logic          Rx_FlagDetect,
  input  logic          Rx_AbortDetect,
  input  logic          Rx_NewByte,
  input  logic [7:0]    Rx_Data,
  input  logic          Rx_Drop,
  input  logic          Rx_RdBuff,
  output logic          Rx_ValidFrame,
  output logic          Rx_WrBuff,
  output logic [AW-1:0] Rx_WrAddr,
  output logic [7:0]    Rx_WrData,
  output logic          Rx_AbortSignal,
  output logic          Rx_Overflow,
  output logic          Rx_EoF,
  output logic          Rx_Ready,
  output logic [7:0]    Rx_FrameSize,
  output logic          Rx_FCSerr
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_BYTES);
  localparam logic [CW-1:0] MINC = CW'(MIN_BYTES);
  localparam logic [CW-1:0] FCSC = CW'(2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          abort_q, abort_d;
  logic          ovf_q, ovf_d;
  logic          eof_q, eof_d;
  logic [7:0]    size_q, size_d;
  logic [7:0]    rd_q, rd_d, rd_nx;

`ifdef HDLC_RX_FCS_EN
  logic [15:0] crc_q, crc_d, crc_eff;
  logic        err_q, err_d;

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction
`endif

  // Next-state: frame tracking, byte writes, close/abort and host release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_eff = cnt_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    abort_d = 1'b0;
    ovf_d   = ovf_q;
    eof_d   = 1'b0;
    size_d  = size_q;
    rd_d    = rd_q;
    rd_nx   = rd_q + 8'(Rx_RdBuff);
`ifdef HDLC_RX_FCS_EN
    crc_d   = crc_q;
    crc_eff = crc_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (RxEN && Rx_FlagDetect) begin
          state_d = S_FRAME;
          cnt_d   = '0;
`ifdef HDLC_RX_FCS_EN
          crc_d   = 16'hFFFF;
`endif
        end
      end
      S_FRAME: begin
        if (!RxEN) begin
          state_d = S_IDLE;
          ovf_d   = 1'b0;
        end else if (Rx_AbortDetect) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          if (Rx_NewByte) begin
            if (cnt_q < MAXC) begin
              wr_d    = 1'b1;
              addr_d  = cnt_q[AW-1:0];
              data_d  = Rx_Data;
              cnt_eff = cnt_q + 1'b1;
`ifdef HDLC_RX_FCS_EN
              crc_eff = crc_byte(crc_q, Rx_Data);
`endif
            end else begin
              ovf_d = 1'b1;
            end
          end
          cnt_d = cnt_eff;
`ifdef HDLC_RX_FCS_EN
          crc_d = crc_eff;
`endif
          // A flag both closes this frame and opens the next one
          if (Rx_FlagDetect) begin
`ifdef HDLC_RX_FCS_EN
            crc_d = 16'hFFFF;
`endif
            if (cnt_eff == '0) begin
              cnt_d = '0;
            end else if (cnt_eff < MINC) begin
              cnt_d = '0;
            end else begin
              state_d = S_DONE;
              eof_d   = 1'b1;
              size_d  = 8'(cnt_eff - FCSC);
              rd_d    = '0;
`ifdef HDLC_RX_FCS_EN
              err_d   = (crc_eff != 16'hF0B8);
`endif
            end
          end
        end
      end
      S_DONE: begin
        rd_d = rd_nx;
        if (Rx_Drop || (rd_nx == size_q)) begin
          state_d = S_IDLE;
          ovf_d   = 1'b0;
          size_d  = '0;
          rd_d    = '0;
`ifdef HDLC_RX_FCS_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
      eof_q   <= 1'b0;
      size_q  <= '0;
      rd_q    <= '0;
`ifdef HDLC_RX_FCS_EN
      crc_q   <= 16'hFFFF;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
      eof_q   <= eof_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
`ifdef HDLC_RX_FCS_EN
      crc_q   <= crc_d;
      err_q   <= err_d;
`endif
    end
  end

  assign Rx_ValidFrame  = (state_q == S_FRAME);
  assign Rx_Ready       = (state_q == S_DONE);
  assign Rx_WrBuff      = wr_q;
  assign Rx_WrAddr      = addr_q;
  assign Rx_WrData      = data_q;
  assign Rx_AbortSignal = abort_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameSize   = size_q;
`ifdef HDLC_RX_FCS_EN
  assign Rx_FCSerr      = err_q;
`else
  assign Rx_FCSerr      = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Bench for hdlc_rx_frame_ctrl: vector table, corner sequences and
// randomized traffic against a frame-level reference model.

module tb_hdlc_rx_frame_ctrl;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic       rst, en, flag, abrt, nb;
    logic [7:0] data;
    logic       drop, rd;
    logic       e_valid, e_wr;
    logic [6:0] e_addr;
    logic       e_eof, e_ready;
    logic [7:0] e_size;
  } vec_t;

`ifdef HDLC_RX_FCS_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       RxEN = 1'b0;
  logic       Rx_FlagDetect = 1'b0;
  logic       Rx_AbortDetect = 1'b0;
  logic       Rx_NewByte = 1'b0;
  logic [7:0] Rx_Data = 8'h00;
  logic       Rx_Drop = 1'b0;
  logic       Rx_RdBuff = 1'b0;
  logic       Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal;
  logic       Rx_Overflow, Rx_EoF, Rx_Ready, Rx_FCSerr;
  logic [6:0] Rx_WrAddr;
  logic [7:0] Rx_WrData, Rx_FrameSize;

  always #5 Clk = ~Clk;

  hdlc_rx_frame_ctrl dut (
    .Clk(Clk), .Rst(Rst), .RxEN(RxEN),
    .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data),
    .Rx_Drop(Rx_Drop), .Rx_RdBuff(Rx_RdBuff),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_WrBuff(Rx_WrBuff),
    .Rx_WrAddr(Rx_WrAddr), .Rx_WrData(Rx_WrData),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_Overflow(Rx_Overflow),
    .Rx_EoF(Rx_EoF), .Rx_Ready(Rx_Ready),
    .Rx_FrameSize(Rx_FrameSize), .Rx_FCSerr(Rx_FCSerr)
  );

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int eof_seen = 0;
  int max_addr = 0;

  // reference model: frame held as a byte queue, receiver in one of three modes
  int         m_mode = 0;
  bq_t        m_q;
  bit         m_ovf = 0;
  int         m_size = 0;
  bit         m_err = 0;
  int         m_reads = 0;
  bit         e_wr = 0, e_abort = 0, e_eof = 0;
  int         e_addr = 0;
  logic [7:0] e_data = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_of(input bq_t b);
    logic [15:0] c;
    bit fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic bq_t with_fcs(input bq_t b);
    bq_t r;
    logic [15:0] f;
    r = b;
    f = ~crc_of(b);
    r.push_back(f[7:0]);
    r.push_back(f[15:8]);
    return r;
  endfunction

  task automatic model_step(input logic rst, en, flag, abrt, nb,
                            input logic [7:0] d, input logic drop, rd);
    int n;
    e_wr = 0; e_abort = 0; e_eof = 0;
    if (rst) begin
      m_mode = 0; m_q.delete(); m_ovf = 0;
      m_size = 0; m_err = 0; m_reads = 0;
    end else if (m_mode == 0) begin
      if (en && flag) begin
        m_mode = 1;
        m_q.delete();
      end
    end else if (m_mode == 1) begin
      if (!en) begin
        m_mode = 0; m_ovf = 0;
      end else if (abrt) begin
        m_mode = 0; m_ovf = 0; e_abort = 1;
      end else begin
        if (nb) begin
          if (m_q.size() < 128) begin
            e_wr = 1; e_addr = m_q.size(); e_data = d;
            m_q.push_back(d);
          end else begin
            m_ovf = 1;
          end
        end
        if (flag) begin
          n = m_q.size();
          if (n >= 3) begin
            m_mode = 2; e_eof = 1; m_size = n - 2; m_reads = 0;
            m_err = (crc_of(m_q) != 16'hF0B8);
          end
          m_q.delete();
        end
      end
    end else begin
      if (rd) m_reads++;
      if (drop || m_reads == m_size) begin
        m_mode = 0; m_ovf = 0; m_size = 0; m_err = 0; m_reads = 0;
      end
    end
  endtask

  task automatic cyc(input logic rst, en, flag, abrt, nb,
                     input logic [7:0] d, input logic drop, rd);
    @(negedge Clk);
    Rst = rst; RxEN = en; Rx_FlagDetect = flag;
    Rx_AbortDetect = abrt; Rx_NewByte = nb; Rx_Data = d;
    Rx_Drop = drop; Rx_RdBuff = rd;
    model_step(rst, en, flag, abrt, nb, d, drop, rd);
    @(posedge Clk);
    #1;
    chk("valid", Rx_ValidFrame, m_mode == 1);
    chk("wrbuff", Rx_WrBuff, e_wr);
    if (e_wr) begin
      chk("wraddr", Rx_WrAddr, e_addr);
      chk("wrdata", Rx_WrData, e_data);
    end
    chk("abort", Rx_AbortSignal, e_abort);
    chk("eof", Rx_EoF, e_eof);
    chk("ready", Rx_Ready, m_mode == 2);
    chk("overflow", Rx_Overflow, m_ovf);
    chk("size", Rx_FrameSize, m_size);
    chk("fcserr", Rx_FCSerr, FCS_ON & m_err);
    if (Rx_WrBuff) begin
      wr_seen++;
      if (int'(Rx_WrAddr) > max_addr) max_addr = int'(Rx_WrAddr);
    end
    if (Rx_EoF) eof_seen++;
  endtask

  task automatic idle_c();     cyc(0, 1, 0, 0, 0, 8'h00, 0, 0); endtask
  task automatic flag_c();     cyc(0, 1, 1, 0, 0, 8'h00, 0, 0); endtask
  task automatic byte_c(input logic [7:0] d); cyc(0, 1, 0, 0, 1, d, 0, 0); endtask
  task automatic rd_c();       cyc(0, 1, 0, 0, 0, 8'h00, 0, 1); endtask
  task automatic drop_c();     cyc(0, 1, 0, 0, 0, 8'h00, 1, 0); endtask

  task automatic send(input bq_t b);
    flag_c();
    foreach (b[i]) byte_c(b[i]);
    flag_c();
  endtask

  vec_t tbl[12];
  bq_t  fr;
  bq_t  bad;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    fr = '{8'h01, 8'h02, 8'h03};
    fr = with_fcs(fr);

    tbl[0]  = '{0,1,0,0,0,8'h00,0,0, 0,0,7'd0,0,0,8'd0};
    tbl[1]  = '{0,1,1,0,0,8'h00,0,0, 1,0,7'd0,0,0,8'd0};
    tbl[2]  = '{0,1,0,0,1,fr[0],0,0, 1,1,7'd0,0,0,8'd0};
    tbl[3]  = '{0,1,0,0,1,fr[1],0,0, 1,1,7'd1,0,0,8'd0};
    tbl[4]  = '{0,1,0,0,1,fr[2],0,0, 1,1,7'd2,0,0,8'd0};
    tbl[5]  = '{0,1,0,0,1,fr[3],0,0, 1,1,7'd3,0,0,8'd0};
    tbl[6]  = '{0,1,0,0,1,fr[4],0,0, 1,1,7'd4,0,0,8'd0};
    tbl[7]  = '{0,1,1,0,0,8'h00,0,0, 0,0,7'd0,1,1,8'd3};
    tbl[8]  = '{0,1,0,0,0,8'h00,0,0, 0,0,7'd0,0,1,8'd3};
    tbl[9]  = '{0,1,0,0,0,8'h00,0,1, 0,0,7'd0,0,1,8'd3};
    tbl[10] = '{0,1,0,0,0,8'h00,0,1, 0,0,7'd0,0,1,8'd3};
    tbl[11] = '{0,1,0,0,0,8'h00,0,1, 0,0,7'd0,0,0,8'd0};

    // reset state
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 0);
    cyc(1, 1, 1, 0, 1, 8'hA5, 0, 0);
    chk("rst_addr", Rx_WrAddr, 0);
    chk("rst_data", Rx_WrData, 0);
    chk("rst_valid", Rx_ValidFrame, 0);
    chk("rst_ready", Rx_Ready, 0);

    // good frame, byte-by-byte
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].flag, tbl[i].abrt,
          tbl[i].nb, tbl[i].data, tbl[i].drop, tbl[i].rd);
      chk("tbl_valid", Rx_ValidFrame, tbl[i].e_valid);
      chk("tbl_wr", Rx_WrBuff, tbl[i].e_wr);
      if (tbl[i].e_wr) chk("tbl_addr", Rx_WrAddr, tbl[i].e_addr);
      chk("tbl_eof", Rx_EoF, tbl[i].e_eof);
      chk("tbl_ready", Rx_Ready, tbl[i].e_ready);
      chk("tbl_size", Rx_FrameSize, tbl[i].e_size);
      chk("tbl_fcserr", Rx_FCSerr, 0);
    end

    // corrupted FCS
    bad = fr;
    bad[4] = bad[4] ^ 8'h01;
    send(bad);
    chk("t2_eof", Rx_EoF, 1);
    chk("t2_fcserr", Rx_FCSerr, FCS_ON);
    drop_c();
    chk("t2_drop_ready", Rx_Ready, 0);
    chk("t2_drop_err", Rx_FCSerr, 0);

    // abort mid-frame
    flag_c();
    for (int i = 0; i < 10; i++) byte_c(8'(i + 16));
    eof_seen = 0;
    cyc(0, 1, 0, 1, 0, 8'h00, 0, 0);
    chk("t3_abort", Rx_AbortSignal, 1);
    chk("t3_valid", Rx_ValidFrame, 0);
    chk("t3_ready", Rx_Ready, 0);
    idle_c();
    chk("t3_abort_pulse", Rx_AbortSignal, 0);
    chk("t3_no_eof", eof_seen, 0);
    flag_c();
    chk("t3_reopen", Rx_ValidFrame, 1);

    // overflow: 130 bytes into a 128-byte buffer
    wr_seen = 0; max_addr = 0;
    for (int i = 0; i < 130; i++) byte_c(8'(i));
    chk("t4_writes", wr_seen, 128);
    chk("t4_maxaddr", max_addr, 127);
    flag_c();
    chk("t4_ovf", Rx_Overflow, 1);
    chk("t4_size", Rx_FrameSize, 126);
    chk("t4_eof", Rx_EoF, 1);
    drop_c();
    chk("t4_ovf_clr", Rx_Overflow, 0);
    chk("t4_ready_clr", Rx_Ready, 0);

    // idle flag, runt, then a 4-byte frame
    eof_seen = 0;
    flag_c(); flag_c();
    byte_c(8'h11); byte_c(8'h22);
    flag_c();
    chk("t5_runt_valid", Rx_ValidFrame, 1);
    for (int i = 0; i < 4; i++) byte_c(8'(8'h30 + i));
    flag_c();
    chk("t5_eofs", eof_seen, 1);
    chk("t5_size", Rx_FrameSize, 2);
    drop_c();

    // frames are lost while held; reads release the held frame
    send(fr);
    chk("t6_size", Rx_FrameSize, 3);
    wr_seen = 0; eof_seen = 0;
    flag_c();
    for (int i = 0; i < 5; i++) byte_c(8'(i + 64));
    flag_c();
    cyc(0, 1, 0, 1, 0, 8'h00, 0, 0);
    chk("t6_no_writes", wr_seen, 0);
    chk("t6_no_eof", eof_seen, 0);
    chk("t6_no_abort", Rx_AbortSignal, 0);
    rd_c(); rd_c();
    chk("t6_ready_held", Rx_Ready, 1);
    rd_c();
    chk("t6_ready_fall", Rx_Ready, 0);

    // reset mid-frame
    flag_c(); byte_c(8'h55); byte_c(8'h66);
    cyc(1, 1, 0, 0, 1, 8'h77, 0, 0);
    chk("t6_rst_valid", Rx_ValidFrame, 0);
    chk("t6_rst_wr", Rx_WrBuff, 0);
    chk("t6_rst_addr", Rx_WrAddr, 0);
    chk("t6_rst_data", Rx_WrData, 0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        cyc(1, 1, 0, 0, 0, 8'h00, 0, 0);
      end else if ($urandom_range(0, 59) == 0) begin
        bq_t g;
        int len;
        len = $urandom_range(1, 8);
        for (int k = 0; k < len; k++) g.push_back(8'($urandom_range(0, 255)));
        send(with_fcs(g));
      end else begin
        cyc(0,
            1'($urandom_range(0, 19) != 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
